// File: rtl/register_move_sequencer_pkg.sv
// Shared types and opcode decode for the register-transfer sequencer.
// Decode is pure combinational; the sequencer registers its result on accept.
// No flow control lives here.
package reg_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LOAD,
        ST_HOLD,
        ST_DONE
    } seq_state_t;

    typedef enum logic [2:0] {
        REG_A  = 3'd0,
        REG_B  = 3'd1,
        REG_C  = 3'd2,
        REG_D  = 3'd3,
        REG_M1 = 3'd4,
        REG_M2 = 3'd5,
        REG_X  = 3'd6,
        REG_Y  = 3'd7
    } reg8_t;

    localparam logic [7:0] OP_MOV8_MASK  = 8'hC0;
    localparam logic [7:0] OP_MOV8_VAL   = 8'h00;
    localparam logic [7:0] OP_MOV16_XY_M = 8'hA0;

    typedef struct packed {
        logic       legal;
        logic       is16;
        logic [7:0] sel8;
        logic [7:0] ld8;
    } dec_t;

    // MOV8 with dst==src is a clear: no source drives the bus, so the
    // destination loads the idle (zero) bus value.
    function automatic dec_t decode_instr(input logic [7:0] instr);
        dec_t  d;
        reg8_t dst;
        reg8_t src;
        d   = '0;
        dst = reg8_t'(instr[5:3]);
        src = reg8_t'(instr[2:0]);
        if ((instr & OP_MOV8_MASK) == OP_MOV8_VAL) begin
            d.legal = 1'b1;
            d.ld8   = 8'd1 << dst;
            if (dst != src) begin
                d.sel8 = 8'd1 << src;
            end
        end else if (instr == OP_MOV16_XY_M) begin
            d.legal = 1'b1;
            d.is16  = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/register_move_sequencer_if.sv
// Handshake and register-unit control bundle for the move sequencer.
// Pure wiring, no latency.
// start is only honoured while the sequencer is idle (busy low).
interface register_move_sequencer_if;
    logic       start;
    logic [7:0] instr;
    logic       busy;
    logic       done;
    logic       illegal;
    logic [7:0] sel8;
    logic [7:0] ld8;
    logic       sel_m;
    logic       ld_xy;

    modport master (
        output start, instr,
        input  busy, done, illegal, sel8, ld8, sel_m, ld_xy
    );

    modport slave (
        input  start, instr,
        output busy, done, illegal, sel8, ld8, sel_m, ld_xy
    );
endinterface

// File: rtl/register_move_sequencer_phase_timer.sv
// Loadable down-counter with terminal-count flag for SETTLE/LOAD phases.
// Loaded value N gives tc after N cycles (tc high in the (N+1)th cycle).
// No backpressure; load has priority over counting.
module seq_phase_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Reload on phase entry, otherwise count down and park at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/register_move_sequencer.sv
// Drives register-unit select/load through settle, load and hold phases.
// Legal op: done in cycle SETTLE+LOAD+2 after accept; illegal: done next cycle.
// start is ignored while busy; next accept no earlier than first IDLE cycle.
module register_move_sequencer
    import reg_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOAD_CYCLES   = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    register_move_sequencer_if.slave   bus
);

    localparam int MAXC = (SETTLE_CYCLES > LOAD_CYCLES) ? SETTLE_CYCLES : LOAD_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    seq_state_t r_state;
    logic       r_busy;
    logic       r_done;
    logic       r_illegal;
    logic [7:0] r_sel8;
    logic [7:0] r_ld8;
    logic       r_sel_m;
    logic       r_ld_xy;
    logic [7:0] r_ld8_cap;
    logic       r_ld_xy_cap;

    dec_t          w_dec;
    logic          w_accept;
    logic          w_tc;
    logic          w_tmr_load;
    logic [CW-1:0] w_tmr_val;

    assign w_dec    = decode_instr(bus.instr);
    assign w_accept = (r_state == ST_IDLE) && bus.start;

    // Counter reloads when entering SETTLE (legal accept) and LOAD.
    assign w_tmr_load = (w_accept && w_dec.legal) || ((r_state == ST_SETTLE) && w_tc);
    assign w_tmr_val  = (r_state == ST_IDLE) ? CW'(SETTLE_CYCLES - 1) : CW'(LOAD_CYCLES - 1);

    seq_phase_timer #(.W(CW)) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc       (w_tc)
    );

    // Sequencer FSM; every output is set here for the state being entered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
            r_sel8      <= '0;
            r_ld8       <= '0;
            r_sel_m     <= 1'b0;
            r_ld_xy     <= 1'b0;
            r_ld8_cap   <= '0;
            r_ld_xy_cap <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_busy <= 1'b1;
                        if (w_dec.legal) begin
                            r_state     <= ST_SETTLE;
                            r_sel8      <= w_dec.sel8;
                            r_sel_m     <= w_dec.is16;
                            r_ld8_cap   <= w_dec.ld8;
                            r_ld_xy_cap <= w_dec.is16;
                        end else begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_illegal <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (w_tc) begin
                        r_state <= ST_LOAD;
                        r_ld8   <= r_ld8_cap;
                        r_ld_xy <= r_ld_xy_cap;
                    end
                end
                ST_LOAD: begin
                    if (w_tc) begin
                        r_state <= ST_HOLD;
                        r_ld8   <= '0;
                        r_ld_xy <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    r_state <= ST_DONE;
                    r_sel8  <= '0;
                    r_sel_m <= 1'b0;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_illegal <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_sel8  <= '0;
                    r_ld8   <= '0;
                    r_sel_m <= 1'b0;
                    r_ld_xy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.illegal = r_illegal;
    assign bus.sel8    = r_sel8;
    assign bus.ld8     = r_ld8;
    assign bus.sel_m   = r_sel_m;
    assign bus.ld_xy   = r_ld_xy;

endmodule

// File: tb/tb_register_move_sequencer.sv
// Directed bench for register_move_sequencer: default timing instance (a)
// and a SETTLE=3/LOAD=2 instance (b). Outputs sampled on the falling edge.
module tb_register_move_sequencer;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    register_move_sequencer_if bus_a ();
    register_move_sequencer_if bus_b ();

    register_move_sequencer u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a.slave)
    );

    register_move_sequencer #(.SETTLE_CYCLES(3), .LOAD_CYCLES(2)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b.slave)
    );

    // {busy, done, illegal, sel_m, ld_xy, sel8[7:0], ld8[7:0]}
    logic [20:0] obs_a;
    logic [20:0] obs_b;
    assign obs_a = {bus_a.busy, bus_a.done, bus_a.illegal, bus_a.sel_m, bus_a.ld_xy, bus_a.sel8, bus_a.ld8};
    assign obs_b = {bus_b.busy, bus_b.done, bus_b.illegal, bus_b.sel_m, bus_b.ld_xy, bus_b.sel8, bus_b.ld8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an instruction on instance a; returns just after the accept edge.
    task automatic start_a(input logic [7:0] ins);
        @(negedge clk);
        bus_a.start = 1'b1;
        bus_a.instr = ins;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
    endtask

    task automatic test_reset;
        logic [20:0] exp;
        #1;
        tests++;
        if (obs_a !== 21'h0) begin
            fails++;
            $display("FAIL reset_a: got %h expected %h", obs_a, 21'h0);
        end
        tests++;
        if (obs_b !== 21'h0) begin
            fails++;
            $display("FAIL reset_b: got %h expected %h", obs_b, 21'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        // MOV A<-D, abort in its LOAD cycle (cycle 3).
        start_a(8'h03);
        repeat (3) @(negedge clk);
        exp = {5'b10000, 8'h08, 8'h01};
        tests++;
        if (obs_a !== exp) begin
            fails++;
            $display("FAIL reset_preload: got %h expected %h", obs_a, exp);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (obs_a !== 21'h0) begin
            fails++;
            $display("FAIL reset_async: got %h expected %h", obs_a, 21'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            tests++;
            if (obs_a !== 21'h0) begin
                fails++;
                $display("FAIL reset_after cycle %0d: got %h expected %h", k, obs_a, 21'h0);
            end
        end
    endtask

    task automatic test_mov8;
        logic [20:0] exp;
        start_a(8'h03);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            exp        = '0;
            exp[20]    = (k <= 5);
            exp[19]    = (k == 5);
            exp[15:8]  = (k <= 4) ? 8'h08 : 8'h00;
            exp[7:0]   = (k == 3) ? 8'h01 : 8'h00;
            tests++;
            if (obs_a !== exp) begin
                fails++;
                $display("FAIL mov8 cycle %0d: got %h expected %h", k, obs_a, exp);
            end
        end
    endtask

    task automatic test_clear;
        logic [20:0] exp;
        start_a(8'h12);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp       = '0;
            exp[20]   = (k <= 5);
            exp[19]   = (k == 5);
            exp[7:0]  = (k == 3) ? 8'h04 : 8'h00;
            tests++;
            if (obs_a !== exp) begin
                fails++;
                $display("FAIL clear cycle %0d: got %h expected %h", k, obs_a, exp);
            end
        end
    endtask

    task automatic test_mov16;
        logic [20:0] exp;
        start_a(8'hA0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp     = '0;
            exp[20] = (k <= 5);
            exp[19] = (k == 5);
            exp[17] = (k <= 4);
            exp[16] = (k == 3);
            tests++;
            if (obs_a !== exp) begin
                fails++;
                $display("FAIL mov16 cycle %0d: got %h expected %h", k, obs_a, exp);
            end
        end
    endtask

    task automatic test_illegal;
        logic [7:0]  ops [3];
        logic [20:0] exp;
        ops[0] = 8'hFF;
        ops[1] = 8'h40;
        ops[2] = 8'hA1;
        for (int i = 0; i < 3; i++) begin
            start_a(ops[i]);
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                exp = (k == 1) ? {5'b11100, 16'h0} : 21'h0;
                tests++;
                if (obs_a !== exp) begin
                    fails++;
                    $display("FAIL illegal %h cycle %0d: got %h expected %h", ops[i], k, obs_a, exp);
                end
            end
        end
    endtask

    // Instance b: MOV Y<-Y then, with start held, MOV A<-B picked up at cycle 8.
    task automatic test_back_to_back;
        logic [20:0] exp;
        int          j;
        @(negedge clk);
        bus_b.start = 1'b1;
        bus_b.instr = 8'h3F;
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp = '0;
            if (k <= 7) begin
                exp[20]   = 1'b1;
                exp[19]   = (k == 7);
                exp[7:0]  = (k == 4 || k == 5) ? 8'h80 : 8'h00;
            end else if (k >= 9) begin
                j         = k - 8;
                exp[20]   = (j <= 7);
                exp[19]   = (j == 7);
                exp[15:8] = (j <= 6) ? 8'h02 : 8'h00;
                exp[7:0]  = (j == 4 || j == 5) ? 8'h01 : 8'h00;
            end
            tests++;
            if (obs_b !== exp) begin
                fails++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", k, obs_b, exp);
            end
            if (k == 2) bus_b.instr = 8'h01;
            if (k == 9) bus_b.start = 1'b0;
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst         = 1'b1;
        bus_a.start = 1'b0;
        bus_a.instr = 8'h00;
        bus_b.start = 1'b0;
        bus_b.instr = 8'h00;
        test_reset();
        test_mov8();
        test_clear();
        test_mov16();
        test_illegal();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
